// File: rtl/master_spi_if.sv
// Bus bundle for the SPI master: host-side request/response plus the serial pins.
interface master_spi_if;
  logic       start;
  logic [7:0] data_in;
  logic       miso;
  logic       sck;
  logic       mosi;
  logic       ss;
  logic       busy;
  logic       done;
  logic [7:0] data_out;

  modport master (input start, data_in, miso,
                  output sck, mosi, ss, busy, done, data_out);
  modport slave  (output start, data_in, miso,
                  input sck, mosi, ss, busy, done, data_out);
endinterface

// File: rtl/master_spi.sv
// Mode-0 SPI master, LSB first, one byte per transfer; sck half-period is DIV clk cycles.
module master_spi #(
  parameter int DIV = 4
) (
  input logic          clk,
  input logic          rst,
  master_spi_if.master bus
);
  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t     state;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [6:0] tx;
  logic [7:0] rx;
  logic       div_end;

  assign div_end = (div_cnt == 8'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      div_cnt      <= 8'd0;
      bit_cnt      <= 4'd0;
      tx           <= 7'd0;
      rx           <= 8'd0;
      bus.sck      <= 1'b0;
      bus.ss       <= 1'b1;
      bus.mosi     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.data_out <= 8'h00;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // bit 0 goes straight to mosi; tx holds the 7 bits still to send
            tx       <= bus.data_in[7:1];
            bus.mosi <= bus.data_in[0];
            bus.ss   <= 1'b0;
            bus.busy <= 1'b1;
            div_cnt  <= 8'd0;
            bit_cnt  <= 4'd0;
            rx       <= 8'd0;
            state    <= LEAD;
          end
        end
        LEAD: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            state   <= XFER;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        XFER: begin
          if (div_end) begin
            div_cnt <= 8'd0;
            bus.sck <= ~bus.sck;
            bit_cnt <= bit_cnt + 4'd1;
            // even half-period count means sck is low and is about to rise
            if (!bit_cnt[0]) begin
              rx <= {bus.miso, rx[7:1]};
            end else if (bit_cnt == 4'd15) begin
              bus.mosi <= 1'b0;
              state    <= TRAIL;
            end else begin
              bus.mosi <= tx[0];
              tx       <= {1'b0, tx[6:1]};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        TRAIL: begin
          if (div_end) begin
            div_cnt      <= 8'd0;
            bus.ss       <= 1'b1;
            bus.data_out <= rx;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_master_spi.sv
// Scoreboarded bench: two masters (DIV=4 and DIV=2) checked for data, bit order, latency and aborts.
module tb_master_spi;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  master_spi_if a();
  master_spi_if b();

  master_spi #(.DIV(4)) u_d4 (.clk(clk), .rst(rst), .bus(a.master));
  master_spi #(.DIV(2)) u_d2 (.clk(clk), .rst(rst), .bus(b.master));

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] tx;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // slave for the DIV=4 master: loads on ss fall, presents bit 0, shifts on sck fall
  logic       loop4 = 1'b0;
  logic [7:0] sbyte4 = 8'h00;
  logic [7:0] slv4 = 8'h00;
  always @(negedge a.ss) slv4 = sbyte4;
  always @(negedge a.sck) slv4 = slv4 >> 1;
  assign a.miso = loop4 ? a.mosi : slv4[0];
  assign b.miso = 1'b1;

  int acc4 = 0, nrise4 = 0, ndone4 = 0, gap4 = 0;
  logic sck4_q = 1'b0, busy4_q = 1'b0;
  logic [7:0] mb4 = 8'h00;
  exp_t e4;

  always @(negedge clk) begin
    if (!rst) begin
      sck4_q  = 1'b0;
      busy4_q = 1'b0;
    end else begin
      if (a.busy && !busy4_q) begin
        chk("d4_ss_gap", 32'(gap4 >= 1), 32'd1);
        gap4   = 0;
        acc4   = cyc;
        mb4    = 8'h00;
        nrise4 = 0;
      end
      if (a.ss) gap4++;
      if (a.sck && !sck4_q) begin
        mb4 = {a.mosi, mb4[7:1]};
        nrise4++;
      end
      if (a.done) begin
        if (q4.size() == 0) begin
          chk("d4_spurious_done", 32'd1, 32'd0);
        end else begin
          e4 = q4.pop_front();
          chk("d4_data_out", 32'(a.data_out), 32'(e4.rx));
          chk("d4_mosi_bits", 32'(mb4), 32'(e4.tx));
          chk("d4_latency", 32'(cyc - acc4), 32'd72);
          chk("d4_rise_cnt", 32'(nrise4), 32'd8);
        end
        ndone4++;
      end
      sck4_q  = a.sck;
      busy4_q = a.busy;
    end
  end

  int acc2 = 0, low2 = 0, ndone2 = 0;
  logic sck2_q = 1'b0, busy2_q = 1'b0;
  logic [7:0] mb2 = 8'h00;
  exp_t e2;

  always @(negedge clk) begin
    if (!rst) begin
      sck2_q  = 1'b0;
      busy2_q = 1'b0;
    end else begin
      if (b.busy && !busy2_q) begin
        acc2 = cyc;
        low2 = 0;
        mb2  = 8'h00;
      end
      if (!b.ss) low2++;
      if (b.sck && !sck2_q) mb2 = {b.mosi, mb2[7:1]};
      if (b.done) begin
        if (q2.size() == 0) begin
          chk("d2_spurious_done", 32'd1, 32'd0);
        end else begin
          e2 = q2.pop_front();
          chk("d2_data_out", 32'(b.data_out), 32'(e2.rx));
          chk("d2_mosi_bits", 32'(mb2), 32'(e2.tx));
          chk("d2_latency", 32'(cyc - acc2), 32'd36);
          chk("d2_ss_low", 32'(low2), 32'd36);
        end
        ndone2++;
      end
      sck2_q  = b.sck;
      busy2_q = b.busy;
    end
  end

  task automatic start4(input logic [7:0] d, input logic [7:0] exp_rx);
    @(negedge clk);
    a.data_in = d;
    a.start   = 1'b1;
    q4.push_back({exp_rx, d});
    @(negedge clk);
    a.start = 1'b0;
  endtask

  task automatic wait_done4(input string tag);
    int n = 0;
    while (!a.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk(tag, 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_rise4(input int k, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (nrise4 < k && n < 500);
    if (n >= 500) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int nd;
    a.start = 1'b0; a.data_in = 8'h00;
    b.start = 1'b0; b.data_in = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(a.sck), 32'd0);
    chk("rst_ss", 32'(a.ss), 32'd1);
    chk("rst_mosi", 32'(a.mosi), 32'd0);
    chk("rst_busy", 32'(a.busy), 32'd0);
    chk("rst_done", 32'(a.done), 32'd0);
    chk("rst_data_out", 32'(a.data_out), 32'd0);
    chk("rst_ss_d2", 32'(b.ss), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // basic transfer against a slave returning 3C
    sbyte4 = 8'h3C;
    start4(8'hA5, 8'h3C);
    wait_done4("basic_timeout");

    // back-to-back with start held, loopback slave
    loop4 = 1'b1;
    @(negedge clk);
    a.data_in = 8'h01;
    a.start   = 1'b1;
    q4.push_back({8'h01, 8'h01});
    q4.push_back({8'hFF, 8'hFF});
    n = 0;
    do begin @(negedge clk); n++; end while (!a.busy && n < 50);
    a.data_in = 8'hFF;
    n = 0;
    while (!a.done && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("b2b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("b2b_restart_busy", 32'(a.busy), 32'd1);
    a.start = 1'b0;
    wait_done4("b2b2_timeout");

    // reset after the third sck rise aborts without done
    loop4  = 1'b0;
    sbyte4 = 8'hE7;
    nd = ndone4;
    @(negedge clk);
    a.data_in = 8'h96;
    a.start   = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    wait_rise4(3, "abort_rise_timeout");
    rst = 1'b0;
    @(negedge clk);
    chk("abort_sck", 32'(a.sck), 32'd0);
    chk("abort_ss", 32'(a.ss), 32'd1);
    chk("abort_busy", 32'(a.busy), 32'd0);
    chk("abort_data_out", 32'(a.data_out), 32'd0);
    a.start = 1'b1;
    a.data_in = 8'h42;
    @(negedge clk);
    chk("rst_start_ignored", 32'(a.busy), 32'd0);
    a.start = 1'b0;
    rst = 1'b1;
    repeat (150) @(negedge clk);
    chk("abort_no_done", 32'(ndone4 - nd), 32'd0);
    chk("abort_still_idle", 32'(a.ss), 32'd1);

    // start pulsed mid-transfer is ignored
    sbyte4 = 8'h5A;
    nd = ndone4;
    start4(8'hC3, 8'h5A);
    wait_rise4(2, "xs_rise_timeout");
    a.data_in = 8'h55;
    a.start   = 1'b1;
    @(negedge clk);
    a.start = 1'b0;
    wait_done4("xs_timeout");
    repeat (100) @(negedge clk);
    chk("xs_one_done", 32'(ndone4 - nd), 32'd1);
    chk("xs_q_empty", 32'(q4.size()), 32'd0);

    // DIV=2 with miso tied high
    @(negedge clk);
    b.data_in = 8'h5A;
    b.start   = 1'b1;
    q2.push_back({8'hFF, 8'h5A});
    @(negedge clk);
    b.start = 1'b0;
    n = 0;
    while (!b.done && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) chk("d2_timeout", 32'd0, 32'd1);
    repeat (5) @(negedge clk);
    chk("d2_one_done", 32'(ndone2), 32'd1);
    chk("d2_q_empty", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
